// File: rtl/ctx_save_ctrl.sv
// Context save/restore sequencer: copies register-file entries 0..NREGS-1 to
// the scratch RAM (save) or back again (restore), one word per clock.
// While idle the CPU owns both memories through a combinational pass-through.
module ctx_save_ctrl #(
  parameter int NREGS = 32
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SAVE,
  input  logic       RESTORE,
  input  logic [7:0] CTX_BASE,
  input  logic [4:0] CPU_ADRX,
  input  logic [7:0] CPU_DIN,
  input  logic       CPU_RF_WR,
  input  logic [7:0] CPU_SCR_ADDR,
  input  logic [9:0] CPU_SCR_DATA,
  input  logic       CPU_SCR_WE,
  output logic [4:0] RF_ADRX,
  output logic [7:0] RF_DIN,
  output logic       RF_WR,
  input  logic [7:0] RF_DX,
  output logic [7:0] SCR_ADDR,
  output logic [9:0] SCR_DATA_IN,
  output logic       SCR_WE,
  input  logic [9:0] SCR_DATA_OUT,
  output logic       BUSY,
  output logic       DONE
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XSAVE = 2'd1,
    XREST = 2'd2,
    FIN   = 2'd3
  } state_t;

  // Index of the final word of a transfer.
  localparam logic [4:0] LAST_IDX = 5'(NREGS - 1);

  state_t     state, state_nxt;
  logic [4:0] idx, idx_nxt;
  logic [7:0] base_q, base_nxt;
  logic [7:0] xfer_addr;

  // Scratch address wraps naturally at 256 through the 8-bit add.
  assign xfer_addr = base_q + {3'b000, idx};

  // State, index and base registers; reset abandons any transfer in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      idx    <= 5'd0;
      base_q <= 8'd0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      base_q <= base_nxt;
    end
  end

  // Next-state sequencing and memory-port steering.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    base_nxt    = base_q;
    RF_ADRX     = CPU_ADRX;
    RF_DIN      = CPU_DIN;
    RF_WR       = CPU_RF_WR;
    SCR_ADDR    = CPU_SCR_ADDR;
    SCR_DATA_IN = CPU_SCR_DATA;
    SCR_WE      = CPU_SCR_WE;
    BUSY        = 1'b0;
    DONE        = 1'b0;

    unique case (state)
      IDLE: begin
        // SAVE has priority; a simultaneous RESTORE is simply dropped.
        if (SAVE) begin
          state_nxt = XSAVE;
          idx_nxt   = 5'd0;
          base_nxt  = CTX_BASE;
        end else if (RESTORE) begin
          state_nxt = XREST;
          idx_nxt   = 5'd0;
          base_nxt  = CTX_BASE;
        end
      end

      XSAVE: begin
        RF_ADRX     = idx;
        RF_DIN      = 8'd0;
        RF_WR       = 1'b0;
        SCR_ADDR    = xfer_addr;
        SCR_DATA_IN = {2'b00, RF_DX};
        SCR_WE      = 1'b1;
        BUSY        = 1'b1;
        if (idx == LAST_IDX) begin
          state_nxt = FIN;
          idx_nxt   = 5'd0;
        end else begin
          idx_nxt   = idx + 5'd1;
        end
      end

      XREST: begin
        RF_ADRX     = idx;
        RF_DIN      = SCR_DATA_OUT[7:0];
        RF_WR       = 1'b1;
        SCR_ADDR    = xfer_addr;
        SCR_DATA_IN = 10'd0;
        SCR_WE      = 1'b0;
        BUSY        = 1'b1;
        if (idx == LAST_IDX) begin
          state_nxt = FIN;
          idx_nxt   = 5'd0;
        end else begin
          idx_nxt   = idx + 5'd1;
        end
      end

      FIN: begin
        // Completion cycle: CPU still locked out, no strobes.
        RF_ADRX     = 5'd0;
        RF_DIN      = 8'd0;
        RF_WR       = 1'b0;
        SCR_ADDR    = 8'd0;
        SCR_DATA_IN = 10'd0;
        SCR_WE      = 1'b0;
        BUSY        = 1'b1;
        DONE        = 1'b1;
        state_nxt   = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
